// File: rtl/ccc_apb_cfg_master.sv
// ccc_apb_cfg_master
// APB-style initiator for the CCC/PLL dynamic-configuration port. Each command
// accepted from the control logic becomes one fixed-length APB transfer
// (SETUP then ACCESS, no PREADY). A write can optionally be followed by a wait
// for the PLL LOCK to stay high for LOCK_STABLE cycles, giving up after
// LOCK_TIMEOUT cycles. Completion is a one-cycle rsp_valid pulse.
//
// Ports:
//   clk, rst_n          block clock (also PCLK), async active-low reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_write/addr/wdata/wait_lock   command fields, latched on acceptance
//   rsp_valid/rdata/err one-cycle response; rdata is 0 for writes, err = lock timeout
//   psel/penable/pwrite/paddr/pwdata   APB request outputs (registered)
//   prdata              APB read data from the CCC
//   pll_lock            asynchronous PLL LOCK, synchronized internally
module ccc_apb_cfg_master #(
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_wait_lock,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [5:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pll_lock
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WAIT_LOCK,
    RESP
  } state_e;

  localparam logic [CNT_W-1:0] STABLE_TGT  = CNT_W'(LOCK_STABLE);
  localparam logic [CNT_W-1:0] TIMEOUT_TGT = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_e           state_q, state_d;
  logic             lockMeta_q, lockSync_q;
  logic [CNT_W-1:0] stableCnt_q, stableCnt_d;
  logic [CNT_W-1:0] toCnt_q, toCnt_d;
  logic             waitLock_q, waitLock_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [5:0]       paddr_q, paddr_d;
  logic [7:0]       pwdata_q, pwdata_d;
  logic             rspValid_q, rspValid_d;
  logic [7:0]       rspRdata_q, rspRdata_d;
  logic             rspErr_q, rspErr_d;

  // Two-flop synchronizer; only lockSync_q is ever looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockMeta_q <= 1'b0;
      lockSync_q <= 1'b0;
    end else begin
      lockMeta_q <= pll_lock;
      lockSync_q <= lockMeta_q;
    end
  end

  // The latched command fields double as the APB address/data/direction
  // registers, so they naturally hold their last value between transfers.
  // Output registers are loaded from the next-state decode so that every
  // output lines up with the state it belongs to.
  always_comb begin
    state_d     = state_q;
    stableCnt_d = stableCnt_q;
    toCnt_d     = toCnt_q;
    waitLock_d  = waitLock_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rspRdata_d  = '0;
    rspErr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d   = cmd_write;
          paddr_d    = cmd_addr;
          pwdata_d   = cmd_wdata;
          waitLock_d = cmd_wait_lock;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // Lock waiting only makes sense after a write to the PLL.
        if (waitLock_q && pwrite_q) begin
          stableCnt_d = '0;
          toCnt_d     = '0;
          state_d     = WAIT_LOCK;
        end else begin
          rspRdata_d = pwrite_q ? 8'h00 : prdata;
          state_d    = RESP;
        end
      end
      WAIT_LOCK: begin
        stableCnt_d = !lockSync_q ? '0 :
                      (stableCnt_q == CNT_MAX) ? stableCnt_q : stableCnt_q + CNT_ONE;
        toCnt_d     = (toCnt_q == CNT_MAX) ? toCnt_q : toCnt_q + CNT_ONE;
        // Stable lock is checked first so it wins a tie with the timeout.
        if (stableCnt_q >= STABLE_TGT) begin
          state_d = RESP;
        end else if (toCnt_q >= TIMEOUT_TGT) begin
          rspErr_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    psel_d     = (state_d == SETUP) || (state_d == ACCESS);
    penable_d  = (state_d == ACCESS);
    rspValid_d = (state_d == RESP);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stableCnt_q <= '0;
      toCnt_q     <= '0;
      waitLock_q  <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rspValid_q  <= 1'b0;
      rspRdata_q  <= '0;
      rspErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      stableCnt_q <= stableCnt_d;
      toCnt_q     <= toCnt_d;
      waitLock_q  <= waitLock_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rspValid_q  <= rspValid_d;
      rspRdata_q  <= rspRdata_d;
      rspErr_q    <= rspErr_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// tb_ccc_apb_cfg_master
// Scoreboard bench for ccc_apb_cfg_master. The stimulus side decides, from its
// own model of when the master should be idle, which commands get accepted and
// pushes the expected transaction (APB phase cycles, response cycle, data,
// error) into a queue. A monitor on the falling clock edge compares the DUT
// outputs against the transaction at the head of the queue every cycle.
// PLL lock and prdata follow per-cycle plans so the model can predict them.
module tb_ccc_apb_cfg_master;

  localparam int LS     = 4;
  localparam int TO     = 20;
  localparam int CW     = 16;
  localparam int PLAN_N = 4096;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       cmd_wait_lock;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [5:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pll_lock;

  typedef struct {
    int         acc;
    int         rsp;
    bit         write;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    bit         err;
  } txn_t;

  txn_t       sbQ[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         cyc        = 0;
  int         modelFree  = 0;
  bit         pllPlan [PLAN_N];
  logic [7:0] prdPlan [PLAN_N];

  ccc_apb_cfg_master #(
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(TO),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wait_lock(cmd_wait_lock),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pll_lock     (pll_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: cycle k is the period that follows the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Synchronized lock seen by the master in cycle k: pll_lock as driven two cycles earlier.
  function automatic bit lockSyncAt(input int k);
    if (k - 2 < 0 || k - 2 >= PLAN_N) return 1'b0;
    return pllPlan[k - 2];
  endfunction

  // Lock wait entered in cycle e: finish at the first cycle k whose preceding
  // LS cycles (all inside the wait) saw lock high; else time out after TO cycles.
  // The response follows one cycle later.
  function automatic void lockOutcome(input int e, output int rspCyc, output bit err);
    bit ok;
    for (int k = e + LS; k <= e + TO; k++) begin
      ok = 1'b1;
      for (int j = k - LS; j < k; j++) if (!lockSyncAt(j)) ok = 1'b0;
      if (ok) begin
        rspCyc = k + 1;
        err    = 1'b0;
        return;
      end
    end
    rspCyc = e + TO + 1;
    err    = 1'b1;
  endfunction

  // Drive one cycle of command inputs; record an expected transaction if the
  // model says the master is idle and would accept it.
  task automatic applyStimulus(input bit valid, input bit write, input logic [5:0] addr,
                               input logic [7:0] wdata, input bit waitLock);
    txn_t t;
    int   r;
    bit   er;
    cmd_valid     = valid;
    cmd_write     = write;
    cmd_addr      = addr;
    cmd_wdata     = wdata;
    cmd_wait_lock = waitLock;
    if (valid && cyc >= modelFree) begin
      t.acc   = cyc;
      t.write = write;
      t.addr  = addr;
      t.wdata = wdata;
      if (write && waitLock) begin
        lockOutcome(cyc + 3, r, er);
        t.rsp = r;
        t.err = er;
      end else begin
        t.rsp = cyc + 3;
        t.err = 1'b0;
      end
      t.rdata = write ? 8'h00 : prdPlan[cyc + 2];
      sbQ.push_back(t);
      modelFree = t.rsp + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, 1'b0);
  endtask

  task automatic waitIdle();
    while (cyc < modelFree) applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, 1'b0);
  endtask

  // Plan-driven PLL lock and CCC read data, updated just after each rising edge.
  initial begin
    for (int i = 0; i < PLAN_N; i++) begin
      pllPlan[i] = 1'b1;
      prdPlan[i] = 8'($urandom);
    end
    pll_lock = pllPlan[0];
    prdata   = prdPlan[0];
    forever begin
      @(posedge clk);
      #1;
      if (cyc < PLAN_N) begin
        pll_lock = pllPlan[cyc];
        prdata   = prdPlan[cyc];
      end
    end
  end

  // Monitor: every cycle out of reset, compare against the head transaction.
  txn_t cur;
  int   ph;
  bit   have;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        have = (sbQ.size() != 0);
        if (have) begin
          cur = sbQ[0];
          ph  = cyc - cur.acc;
        end else begin
          ph = -1;
        end
        checkOutput("cmd_ready", int'(cmd_ready), int'(!have || ph == 0));
        checkOutput("psel", int'(psel), int'(ph == 1 || ph == 2));
        checkOutput("penable", int'(penable), int'(ph == 2));
        if (ph == 1 || ph == 2) begin
          checkOutput("paddr", int'(paddr), int'(cur.addr));
          checkOutput("pwrite", int'(pwrite), int'(cur.write));
          if (cur.write) checkOutput("pwdata", int'(pwdata), int'(cur.wdata));
        end
        checkOutput("rsp_valid", int'(rsp_valid), int'(have && cyc == cur.rsp));
        if (have && cyc == cur.rsp) begin
          checkOutput("rsp_rdata", int'(rsp_rdata), int'(cur.rdata));
          checkOutput("rsp_err", int'(rsp_err), int'(cur.err));
          void'(sbQ.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    int e;
    int budget;
    bit w;
    bit wl;
    int mode;

    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_addr      = 6'h00;
    cmd_wdata     = 8'h00;
    cmd_wait_lock = 1'b0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] checking reset state");
    checkOutput("reset_cmd_ready", int'(cmd_ready), 1);
    checkOutput("reset_psel", int'(psel), 0);
    checkOutput("reset_penable", int'(penable), 0);
    checkOutput("reset_pwrite", int'(pwrite), 0);
    checkOutput("reset_paddr", int'(paddr), 0);
    checkOutput("reset_pwdata", int'(pwdata), 0);
    checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset_rsp_rdata", int'(rsp_rdata), 0);
    checkOutput("reset_rsp_err", int'(rsp_err), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idleCycles(3);

    $display("[TB] directed write");
    applyStimulus(1'b1, 1'b1, 6'h05, 8'hA3, 1'b0);
    waitIdle();
    idleCycles(1);

    $display("[TB] directed read");
    prdPlan[cyc + 2] = 8'h5C;
    prdPlan[cyc + 3] = 8'hFF;
    applyStimulus(1'b1, 1'b0, 6'h12, 8'h00, 1'b0);
    waitIdle();

    $display("[TB] lock wait with glitchy lock");
    c = cyc;
    e = c + 3;
    for (int i = 0; i < 30; i++)
      pllPlan[e - 2 + i] = (i < 10) ? 1'b0 : (i < 12) ? 1'b1 : (i == 12) ? 1'b0 : 1'b1;
    applyStimulus(1'b1, 1'b1, 6'h2A, 8'h3C, 1'b1);
    waitIdle();

    $display("[TB] lock timeout then read");
    c = cyc;
    for (int i = 1; i <= 30; i++) pllPlan[c + i] = 1'b0;
    applyStimulus(1'b1, 1'b1, 6'h01, 8'h80, 1'b1);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 6'h3F, 8'h00, 1'b0);
    waitIdle();

    $display("[TB] busy: cmd_valid held for 8 cycles");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 6'(i * 7 + 3), 8'(i), 1'b0);
    idleCycles(2);
    waitIdle();

    $display("[TB] randomized commands");
    repeat (40) begin
      idleCycles($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      wl = 1'($urandom_range(0, 1));
      if (w && wl) begin
        c    = cyc;
        mode = $urandom_range(0, 3);
        for (int i = 1; i <= TO + 4; i++)
          pllPlan[c + i] = (mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
      applyStimulus(1'b1, w, 6'($urandom), 8'($urandom), wl);
      while (cyc < modelFree)
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom),
                      8'($urandom), 1'($urandom_range(0, 1)));
    end
    idleCycles(2);

    $display("[TB] reset during ACCESS");
    applyStimulus(1'b1, 1'b0, 6'h15, 8'h00, 1'b0);
    cmd_valid = 1'b0;
    @(posedge clk);
    #3;
    checkOutput("pre_reset_psel", int'(psel), 1);
    checkOutput("pre_reset_penable", int'(penable), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_psel", int'(psel), 0);
    checkOutput("async_reset_penable", int'(penable), 0);
    checkOutput("async_reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("async_reset_paddr", int'(paddr), 0);
    checkOutput("async_reset_cmd_ready", int'(cmd_ready), 1);
    sbQ.delete();
    modelFree = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idleCycles(6);

    budget = 0;
    while (sbQ.size() != 0 && budget < 200) begin
      idleCycles(1);
      budget++;
    end
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ccc_apb_cfg_master.md
Name: ccc_apb_cfg_master

Overview:
- APB-style initiator that drives the CCC/PLL dynamic-configuration port: PSEL, PENABLE, PWRITE, PADDR[5:0], PWDATA[7:0] out; PRDATA[7:0] in.
- Accepts single read/write commands from the control logic and runs one APB transfer per command.
- On request, waits for the PLL LOCK to re-assert and stay stable after a write.
- Sits between the command/register decoder and the fabric CCC instance, in the always-on clock domain.

Parameters:
- LOCK_STABLE, 64, consecutive synchronized-LOCK-high cycles needed to declare lock; range 1..65535.
- LOCK_TIMEOUT, 65535, maximum cycles spent in WAIT_LOCK before flagging an error; must be greater than LOCK_STABLE.
- CNT_W, 16, width of the stable and timeout counters.

Ports:
- clk  input  1  single block clock; also serves as PCLK.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  6  CCC register address.
- cmd_wdata  input  8  write data.
- cmd_wait_lock  input  1  after the transfer, wait for PLL lock.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  8  read data; 0 for writes.
- rsp_err  output  1  lock timeout; valid with rsp_valid.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  6  APB address.
- pwdata  output  8  APB write data.
- prdata  input  8  APB read data from the CCC.
- pll_lock  input  1  asynchronous PLL LOCK.

Behaviour:
- Reset: clk single clock; rst_n asynchronous assert, active-low. While reset is asserted, all outputs are 0 except cmd_ready; the state is IDLE; counters and the synchronizer are cleared. cmd_ready is a decode of IDLE, so it is 1 once rst_n is released.
- pll_lock passes through a 2-FF synchronizer to lock_s; nothing uses pll_lock directly.
- All APB outputs and rsp_* are registered.
- States:
  - IDLE: cmd_ready=1. When cmd_valid is high, latch write/addr/wdata/wait_lock and go to SETUP. cmd_* is ignored in every other state, with no queueing.
  - SETUP: psel=1, penable=0, paddr/pwrite/pwdata driven from the latched values. Always advances to ACCESS.
  - ACCESS: psel=1, penable=1. There is no PREADY; the access is fixed at one cycle. Reads capture prdata at the end of ACCESS. Next state is WAIT_LOCK if wait_lock&write, otherwise RESP. wait_lock on a read is ignored.
  - WAIT_LOCK: psel=penable=0.
    - stable_cnt increments while lock_s=1 and clears to 0 when lock_s=0.
    - to_cnt increments every cycle.
    - When stable_cnt reaches LOCK_STABLE, go to RESP with err=0.
    - Otherwise, when to_cnt reaches LOCK_TIMEOUT, go to RESP with err=1.
    - If both happen in the same cycle, stable wins (err=0).
    - Both counters clear on entry.
  - RESP: rsp_valid=1 for exactly one cycle; rsp_rdata = captured prdata for reads, 0 for writes. Returns to IDLE. There is no response backpressure.
- Latency: command accepted at cycle N gives SETUP at N+1, ACCESS at N+2, rsp_valid at N+3 (no lock wait). With lock wait, rsp_valid comes 1 cycle after the terminating WAIT_LOCK cycle.
- Back-to-back commands: the next command can be accepted in the cycle after RESP, so the minimum period is 4 cycles.
- Outside SETUP/ACCESS: paddr/pwdata/pwrite hold their last values; psel=penable=0.
- Reset mid-transfer: outputs clear immediately (asynchronous). No response is issued for the aborted command.
- Counters saturate and never wrap; the width is CNT_W.

Test Plan:
- Write: cmd addr=0x05, wdata=0xA3, wait_lock=0 → psel=1/penable=0 at N+1; psel=1/penable=1, pwrite=1, paddr=0x05, pwdata=0xA3 at N+2; rsp_valid=1, rsp_err=0, rsp_rdata=0x00 at N+3; cmd_ready=1 at N+4.
- Read: addr=0x12 with prdata=0x5C in ACCESS → pwrite=0 throughout; rsp_rdata=0x5C at N+3. prdata changing to 0xFF after ACCESS does not alter the response.
- Lock wait, LOCK_STABLE=4: write with wait_lock=1; pll_lock low 10 cycles, high 2, low 1, then high → rsp_valid exactly 4 cycles after the final rising edge of lock_s, plus 1; rsp_err=0.
- Timeout, LOCK_TIMEOUT=20: pll_lock held 0 → rsp_valid with rsp_err=1 at WAIT_LOCK entry + 21. Then issue a read → it completes normally with rsp_err=0.
- Busy: cmd_valid held high for 8 cycles with different addr values → exactly 2 transfers; each uses the address present at its acceptance cycle; cmd_ready=0 from N+1 to N+3.
- Reset during ACCESS: deassert rst_n → psel, penable, rsp_valid drop to 0 without waiting for a clock edge; no rsp_valid after release; cmd_ready=1 once rst_n is released.
